// File: rtl/pc_counter.sv
// Program counter register: loads pc_next every cycle, exposes pc + 4 and a
// registered misalignment flag. Asynchronous active-low reset to RESET_VECTOR.
module pc_counter #(
    parameter int unsigned           WIDTH        = 32,
    parameter logic [WIDTH-1:0]      RESET_VECTOR = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;
    logic             misaligned_d;
    logic             misaligned_q;

    // Next state: unconditional load, value taken unmodified.
    always_comb begin
        pc_d         = pc_next;
        misaligned_d = (pc_next[1:0] != 2'b00);
    end

    // Flag is forced clear in reset regardless of RESET_VECTOR alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc         = pc_q;
    assign misaligned = misaligned_q;
    // Sequential-fetch address; wraps modulo 2^WIDTH with no carry out.
    assign pc_plus4   = pc_q + PC_STEP;

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: expected pc/flag/pc+4 triples are queued
// when stimulus is applied and compared when the DUT output is sampled.
module tb_pc_counter;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic [31:0] p4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    pc_counter #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_next    (pc_next),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] v);
        exp_t e;
        e.pc  = v;
        e.mis = (v[1:0] != 2'b00);
        e.p4  = v + 32'd4;
        return e;
    endfunction

    function automatic exp_t mk_rst();
        exp_t e;
        e.pc  = 32'h0000_0000;
        e.mis = 1'b0;
        e.p4  = 32'h0000_0004;
        return e;
    endfunction

    // Pop the oldest expectation and compare all three outputs against it.
    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pc"}, pc, e.pc);
            check({tag, "_mis"}, {31'd0, misaligned}, {31'd0, e.mis});
            check({tag, "_p4"}, pc_plus4, e.p4);
        end
    endtask

    // Drive a value away from the edge, then check it was loaded by the next edge.
    task automatic load(input string tag, input logic [31:0] v);
        @(negedge clk);
        pc_next = v;
        exp_q.push_back(mk(v));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        pc_next = 32'h0000_001A;

        // Reset asserted, no clock edge yet.
        #2;
        exp_q.push_back(mk_rst());
        pop_check("rst_no_edge");

        // Clock edges during reset must not load pc_next.
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk_rst());
        pop_check("rst_edges");

        // Release reset away from the edge; first edge loads normally.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_q.push_back(mk_rst());
        pop_check("rst_released");
        @(posedge clk);
        #1;
        exp_q.push_back(mk(32'h0000_001A));
        pop_check("first_load_1a");

        // pc holds 0x1A until the edge after pc_next changes to 0.
        @(negedge clk);
        pc_next = 32'h0000_0000;
        #2;
        exp_q.push_back(mk(32'h0000_001A));
        pop_check("hold_before_edge");
        exp_q.push_back(mk(32'h0000_0000));
        @(posedge clk);
        #1;
        pop_check("load_zero");

        load("wrap_p4", 32'hFFFF_FFFC);
        load("all_ones", 32'hFFFF_FFFF);
        load("mis_2", 32'h0000_0002);
        load("aligned_big", 32'h8000_0000);

        // Several pc_next changes between edges: only the last one is taken.
        @(negedge clk);
        pc_next = 32'h0000_1111;
        #1 pc_next = 32'h0000_2222;
        #1 pc_next = 32'h0000_3333;
        #1;
        exp_q.push_back(mk(32'h8000_0000));
        pop_check("toggle_hold");
        pc_next = 32'h0000_4445;
        exp_q.push_back(mk(32'h0000_4445));
        @(posedge clk);
        #1;
        pop_check("toggle_last");
        pc_next = 32'h0000_5550;
        #2;
        pc_next = 32'h0000_6660;
        #1;
        exp_q.push_back(mk(32'h0000_4445));
        pop_check("toggle_after_edge");

        // Asynchronous reset between edges.
        load("pre_async", 32'h0000_0100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk_rst());
        pop_check("async_rst");

        // Reset held across an edge overrides the pending load.
        pc_next = 32'h0000_0055;
        @(posedge clk);
        #1;
        exp_q.push_back(mk_rst());
        pop_check("rst_override");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(32'h0000_0055));
        pop_check("post_rst_load");

        // Random loads.
        for (int i = 0; i < 12; i++) begin
            load("rand", 32'($urandom));
        end

        if (exp_q.size() != 0) begin
            check("queue_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
